// File: rtl/svi_lane_pkg.sv
// Shared types and constants for the latch-lane write controller.
package svi_lane_pkg;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_CLEAR = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD,
        CHECK,
        CLEAR
    } state_e;

    localparam int ERR_CNT_W = 8;

    // Largest of the three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/svi_lane_writer_timer.sv
// Loadable down-counter with a zero flag; times each phase of a lane command.
module lane_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/svi_lane_writer.sv
// Drives an array of latch lanes: sequences clear/data/enable with setup,
// open and hold phases, then reads the addressed lane(s) back.
module svi_lane_writer
    import svi_lane_pkg::*;
#(
    parameter int M         = 8,
    parameter int IDX_W     = $clog2(M),
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_op,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic                 i_d,
    output logic                 o_lane_clr_n,
    output logic [M-1:0]         o_lane_en,
    output logic [M-1:0]         o_lane_d,
    input  logic [M-1:0]         i_lane_q,
    output logic                 o_done,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC) + 1);

    state_e               state_q, state_d;
    op_e                  op_q;
    logic                 d_q;
    logic [M-1:0]         sel_q;       // one-hot target lane, all-zero for a bad index
    logic [M-1:0]         sel_in;
    logic [M-1:0]         lane_en_q, lane_en_d;
    logic [M-1:0]         lane_d_q, lane_d_d;
    logic                 lane_clr_n_q, lane_clr_n_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 accept;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_zero;

    // Decode the incoming index to a one-hot lane select; out-of-range gives zero.
    for (genvar gi = 0; gi < M; gi++) begin : g_sel
        assign sel_in[gi] = (i_idx == IDX_W'(gi));
    end

    assign accept  = i_valid && (state_q == IDLE);
    assign o_ready = (state_q == IDLE);

    lane_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk_i     (i_clk),
        .arst_i    (i_arst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero)
    );

    // Next-state logic; each timed phase reloads the counter on entry.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (op_e'(i_op) == OP_CLEAR) begin
                        state_d  = CLEAR;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(OPEN_CYC - 1);
                    end else if (sel_in == '0) begin
                        state_d  = CHECK;
                    end else begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(OPEN_CYC - 1);
                end
            end
            OPEN: begin
                if (tmr_zero) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end
            end
            CLEAR: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane outputs are computed from the upcoming state and registered, so
    // data only moves at acceptance while every enable is low.
    always_comb begin
        lane_d_d = lane_d_q;
        if (accept) begin
            if (op_e'(i_op) == OP_CLEAR) begin
                lane_d_d = '0;
            end else begin
                lane_d_d = (lane_d_q & ~sel_in) | (sel_in & {M{i_d}});
            end
        end
        lane_en_d    = (state_d == OPEN) ? sel_q : '0;
        lane_clr_n_d = (state_d != CLEAR);
    end

    // State, captured command and registered lane-side outputs.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= IDLE;
            op_q         <= OP_WRITE;
            d_q          <= 1'b0;
            sel_q        <= '0;
            lane_en_q    <= '0;
            lane_d_q     <= '0;
            lane_clr_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_en_q    <= lane_en_d;
            lane_d_q     <= lane_d_d;
            lane_clr_n_q <= lane_clr_n_d;
            if (accept) begin
                op_q  <= op_e'(i_op);
                d_q   <= i_d;
                sel_q <= sel_in;
            end
        end
    end

    // Completion and readback verdict are presented during CHECK.
    always_comb begin
        o_done = (state_q == CHECK);
        o_err  = 1'b0;
        if (state_q == CHECK) begin
            if (op_q == OP_CLEAR) begin
                o_err = |i_lane_q;
            end else begin
                o_err = (sel_q == '0) || (|((i_lane_q ^ {M{d_q}}) & sel_q));
            end
        end
    end

    // Saturating count of commands that completed with an error.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            err_cnt_q <= '0;
        end else if (o_done && o_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign o_lane_clr_n = lane_clr_n_q;
    assign o_lane_en    = lane_en_q;
    assign o_lane_d     = lane_d_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_svi_lane_writer.sv
// Randomized self-checking bench for svi_lane_writer with a latch-lane model.
module tb_svi_lane_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default timing, index widened to reach out-of-range lanes.
    logic       arst_a, valid_a, ready_a, op_a, d_a, clr_n_a, done_a, err_a, stuck_a;
    logic [3:0] idx_a;
    logic [7:0] en_a, ld_a, q_a, cnt_a;

    // Instance B: stretched phases.
    logic       arst_b, valid_b, ready_b, op_b, d_b, clr_n_b, done_b, err_b;
    logic [2:0] idx_b;
    logic [7:0] en_b, ld_b, q_b, cnt_b;

    svi_lane_writer #(.M(8), .IDX_W(4)) dut_a (
        .i_clk(clk), .i_arst(arst_a), .i_valid(valid_a), .o_ready(ready_a),
        .i_op(op_a), .i_idx(idx_a), .i_d(d_a), .o_lane_clr_n(clr_n_a),
        .o_lane_en(en_a), .o_lane_d(ld_a), .i_lane_q(q_a), .o_done(done_a),
        .o_err(err_a), .o_err_cnt(cnt_a)
    );

    svi_lane_writer #(.M(8), .IDX_W(3), .SETUP_CYC(3), .OPEN_CYC(2), .HOLD_CYC(2)) dut_b (
        .i_clk(clk), .i_arst(arst_b), .i_valid(valid_b), .o_ready(ready_b),
        .i_op(op_b), .i_idx(idx_b), .i_d(d_b), .o_lane_clr_n(clr_n_b),
        .o_lane_en(en_b), .o_lane_d(ld_b), .i_lane_q(q_b), .o_done(done_b),
        .o_err(err_b), .o_err_cnt(cnt_b)
    );

    // Lane models: clear forces 0, an open enable copies data, else hold.
    always @(posedge clk) begin
        if (!clr_n_a || stuck_a) q_a <= 8'h00;
        else                     q_a <= (q_a & ~en_a) | (ld_a & en_a);
    end
    always @(posedge clk) begin
        if (!clr_n_b) q_b <= 8'h00;
        else          q_b <= (q_b & ~en_b) | (ld_b & en_b);
    end

    // Reference state for instance A.
    bit [7:0] ref_ld;
    bit [7:0] ref_q;
    int       exp_cnt;

    // One command on A, checked cycle by cycle against the reference.
    task automatic do_cmd_a(input bit op, input int idx, input bit d);
        bit          bad;
        int          lat;
        bit [7:0]    oh;
        bit          exp_err;
        logic [18:0] exp_v, got_v;
        bad     = !op && (idx >= 8);
        lat     = bad ? 1 : (op ? 2 : 4);
        oh      = (!op && !bad) ? (8'd1 << idx) : 8'd0;
        exp_err = 1'b0;
        if (op) begin
            ref_ld = 8'h00;
            ref_q  = 8'h00;
        end else if (bad) begin
            exp_err = 1'b1;
        end else begin
            ref_ld[idx] = d;
            ref_q[idx]  = stuck_a ? 1'b0 : d;
            exp_err     = (ref_q[idx] != d);
        end
        if (exp_err && exp_cnt < 255) exp_cnt++;

        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1)
            $display("FAIL ready_before_cmd got=%b want=1", ready_a);
        valid_a = 1'b1; op_a = op; idx_a = idx[3:0]; d_a = d;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            valid_a = 1'b0;
            exp_v = {((k == 2) ? oh : 8'h00), ref_ld, !(op && k == 1), (k == lat), 1'b0};
            got_v = {en_a, ld_a, clr_n_a, done_a, ready_a};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL cmd_cycle op=%0d idx=%0d d=%0d k=%0d {en,d,clr_n,done,rdy} got=%h want=%h",
                         op, idx, d, k, got_v, exp_v);
            end
            if (k == lat) begin
                checks++;
                if (err_a !== exp_err) begin
                    failures++;
                    $display("FAIL cmd_err op=%0d idx=%0d d=%0d got=%b want=%b", op, idx, d, err_a, exp_err);
                end
            end
        end
        @(negedge clk);
        exp_v = {8'h00, ref_ld, 1'b1, 1'b0, 1'b1};
        got_v = {en_a, ld_a, clr_n_a, done_a, ready_a};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL cmd_after op=%0d idx=%0d got=%h want=%h", op, idx, got_v, exp_v);
        end
        checks++;
        if (cnt_a !== exp_cnt[7:0]) begin
            failures++;
            $display("FAIL err_cnt op=%0d idx=%0d got=%0d want=%0d", op, idx, cnt_a, exp_cnt);
        end
        $display("cmd op=%0d idx=%0d d=%0d err=%0d cnt=%0d", op, idx, d, exp_err, exp_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({en_a, ld_a, clr_n_a, done_a, err_a, cnt_a} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {en_a, ld_a, clr_n_a, done_a, err_a, cnt_a});
        end
        @(posedge clk);
        #1 arst_a = 1'b0; arst_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_a, ready_b} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_reset got=%b want=11", {ready_a, ready_b});
        end
        ref_ld = 8'h00; ref_q = 8'h00; exp_cnt = 0;
        $display("reset released ready=%b%b", ready_a, ready_b);
    endtask

    task automatic test_write();
        do_cmd_a(1'b0, 3, 1'b1);
    endtask

    task automatic test_clear();
        do_cmd_a(1'b0, 0, 1'b1);
        do_cmd_a(1'b0, 5, 1'b1);
        do_cmd_a(1'b1, 0, 1'b0);
        checks++;
        if (q_a !== 8'h00) begin
            failures++;
            $display("FAIL lanes_after_clear got=%h want=00", q_a);
        end
    endtask

    task automatic test_bad_idx();
        do_cmd_a(1'b0, 9, 1'b1);
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL bad_idx_cnt got=%0d want=1", cnt_a);
        end
    endtask

    task automatic test_stuck();
        stuck_a = 1'b1;
        repeat (2) @(negedge clk);
        ref_q = 8'h00;
        do_cmd_a(1'b0, 2, 1'b1);
        repeat (300) do_cmd_a(1'b0, $urandom_range(0, 7), 1'b1);
        checks++;
        if (cnt_a !== 8'd255) begin
            failures++;
            $display("FAIL err_cnt_saturate got=%0d want=255", cnt_a);
        end
        stuck_a = 1'b0;
    endtask

    task automatic test_arst_open();
        @(negedge clk);
        valid_a = 1'b1; op_a = 1'b0; idx_a = 4'd4; d_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        checks++;
        if (en_a !== 8'h10) begin
            failures++;
            $display("FAIL open_before_arst got=%h want=10", en_a);
        end
        #1 arst_a = 1'b1;
        #1;
        checks++;
        if ({en_a, clr_n_a, done_a, cnt_a} !== 18'd0) begin
            failures++;
            $display("FAIL arst_async got=%h want=0", {en_a, clr_n_a, done_a, cnt_a});
        end
        @(posedge clk);
        #1 arst_a = 1'b0;
        ref_ld = 8'h00; ref_q = 8'h00; exp_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0) begin
                failures++;
                $display("FAIL no_done_after_arst k=%0d got=%b want=0", k, done_a);
            end
            if (k == 1) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_after_arst got=%b want=1", ready_a);
                end
            end
        end
        $display("arst during OPEN aborted command");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_cmd_a(($urandom_range(0, 3) == 0), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    endtask

    // Stretched phases with valid held: setup 1-3, open 4-5, hold 6-7,
    // check 8, second accept at edge 9.
    task automatic test_back_to_back();
        logic [11:0] exp_v, got_v;
        @(negedge clk);
        valid_b = 1'b1; op_b = 1'b0; idx_b = 3'd7; d_b = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp_v = {(((k >= 4 && k <= 5) || (k >= 13 && k <= 14)) ? 8'h80 : 8'h00),
                     1'b1, 1'b1, (k == 8 || k == 17), (k == 9 || k == 18)};
            got_v = {en_b, ld_b[7], clr_n_b, done_b, ready_b};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL b2b k=%0d {en,d7,clr_n,done,rdy} got=%h want=%h", k, got_v, exp_v);
            end
            if (k == 8 || k == 17) begin
                checks++;
                if (err_b !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_err k=%0d got=%b want=0", k, err_b);
                end
            end
            if (k == 10) valid_b = 1'b0;
        end
        $display("back_to_back two writes idx=7 done at 8 and 17");
    endtask

    initial begin
        arst_a = 1'b1; arst_b = 1'b1; stuck_a = 1'b0;
        valid_a = 1'b0; op_a = 1'b0; idx_a = 4'd0; d_a = 1'b0;
        valid_b = 1'b0; op_b = 1'b0; idx_b = 3'd0; d_b = 1'b0;
        ref_ld = 8'h00; ref_q = 8'h00; exp_cnt = 0;
        test_reset();
        test_write();
        test_clear();
        test_bad_idx();
        test_stuck();
        test_arst_open();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
